// File: rtl/codec_init_sequencer.sv
// Codec init sequencer: walks a ROM of {reg, value} writes and hands each one to
// the I2C engine over its go/rdy handshake, with power-on wait, inter-write gap and NAK retry.
module codec_init_sequencer #(
   parameter int N_CMDS       = 16,
   parameter int DELAY_CYCLES = 1000,
   parameter int POR_WAIT     = 65535,
   parameter int MAX_RETRY    = 3,
   parameter int AUTO_START   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  err_idx,
   output logic [7:0]  cmd_idx,
   input  logic [15:0] cmd_word,
   output logic        i2c_go,
   input  logic        i2c_rdy,
   input  logic        i2c_nak,
   output logic [7:0]  i2c_reg,
   output logic [7:0]  i2c_data
);

   // Counter load values are "clocks - 1"; a zero request still spends one clock.
   localparam logic [23:0] POR_LOAD  = (POR_WAIT > 0) ? 24'(POR_WAIT - 1) : 24'd0;
   localparam logic [23:0] GAP_LOAD  = (DELAY_CYCLES > 0) ? 24'(DELAY_CYCLES - 1) : 24'd0;
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
   localparam logic [7:0]  END_IDX   = 8'(N_CMDS);

   typedef enum logic [3:0] {
      S_IDLE, S_POR, S_FETCH, S_LOAD, S_ISSUE,
      S_WAIT_ACC, S_WAIT_DONE, S_GAP, S_DONE, S_ERROR
   } state_t;

   state_t      r_state;
   logic [23:0] r_cnt;
   logic [3:0]  r_retry;
   logic        r_gap_to_issue;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [7:0]  r_err_idx;
   logic [7:0]  r_cmd_idx;
   logic        r_go;
   logic [7:0]  r_reg;
   logic [7:0]  r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= (AUTO_START != 0) ? S_POR : S_IDLE;
         r_cnt          <= POR_LOAD;
         r_retry        <= 4'd0;
         r_gap_to_issue <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_err_idx      <= 8'd0;
         r_cmd_idx      <= 8'd0;
         r_go           <= 1'b0;
         r_reg          <= 8'd0;
         r_data         <= 8'd0;
      end else begin
         r_go <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cmd_idx <= 8'd0;
                  r_retry   <= 4'd0;
                  r_busy    <= 1'b1;
                  r_state   <= S_FETCH;
               end
            end
            S_POR: begin
               if (r_cnt == 24'd0) begin
                  r_cmd_idx <= 8'd0;
                  r_retry   <= 4'd0;
                  r_busy    <= 1'b1;
                  r_state   <= S_FETCH;
               end else begin
                  r_cnt <= r_cnt - 24'd1;
               end
            end
            // The ROM answers one clock after cmd_idx, so LOAD sees the word.
            S_FETCH: r_state <= S_LOAD;
            S_LOAD: begin
               if (cmd_word == 16'hFFFF || r_cmd_idx == END_IDX) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_reg   <= cmd_word[15:8];
                  r_data  <= cmd_word[7:0];
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (i2c_rdy) begin
                  r_go    <= 1'b1;
                  r_state <= S_WAIT_ACC;
               end
            end
            S_WAIT_ACC: begin
               if (!i2c_rdy) r_state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (i2c_rdy) begin
                  if (!i2c_nak) begin
                     r_cmd_idx      <= r_cmd_idx + 8'd1;
                     r_retry        <= 4'd0;
                     r_gap_to_issue <= 1'b0;
                     r_cnt          <= GAP_LOAD;
                     r_state        <= S_GAP;
                  end else if (r_retry < RETRY_MAX) begin
                     r_retry        <= r_retry + 4'd1;
                     r_gap_to_issue <= 1'b1;
                     r_cnt          <= GAP_LOAD;
                     r_state        <= S_GAP;
                  end else begin
                     r_err     <= 1'b1;
                     r_err_idx <= r_cmd_idx;
                     r_busy    <= 1'b0;
                     r_state   <= S_ERROR;
                  end
               end
            end
            // A retry re-issues the latched reg/data without touching the ROM.
            S_GAP: begin
               if (r_cnt == 24'd0) begin
                  r_state <= r_gap_to_issue ? S_ISSUE : S_FETCH;
               end else begin
                  r_cnt <= r_cnt - 24'd1;
               end
            end
            S_DONE: begin
               if (start) begin
                  r_done    <= 1'b0;
                  r_cmd_idx <= 8'd0;
                  r_retry   <= 4'd0;
                  r_busy    <= 1'b1;
                  r_state   <= S_FETCH;
               end
            end
            S_ERROR: begin
               if (start) begin
                  r_err     <= 1'b0;
                  r_err_idx <= 8'd0;
                  r_cmd_idx <= 8'd0;
                  r_retry   <= 4'd0;
                  r_busy    <= 1'b1;
                  r_state   <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;
   assign err_idx  = r_err_idx;
   assign cmd_idx  = r_cmd_idx;
   assign i2c_go   = r_go;
   assign i2c_reg  = r_reg;
   assign i2c_data = r_data;

endmodule
